// File: rtl/mod_pkg.sv
// Shared definitions for the time-base generator: command field layout and FSM states.
// The field offsets depend on N and BT, so the top derives its own copies from these helpers.
package mod_pkg;

    localparam int DEF_N  = 10;
    localparam int DEF_BT = 8;

    function automatic int cmd_len_lsb(input int n);
        return n;
    endfunction

    function automatic int cmd_phrst_bit(input int n, input int bt);
        return n + bt;
    endfunction

    function automatic int cmd_periodic_bit(input int n, input int bt);
        return n + bt + 1;
    endfunction

    localparam int ADDR_LSB     = 0;
    localparam int LEN_LSB      = cmd_len_lsb(DEF_N);
    localparam int PHRST_BIT    = cmd_phrst_bit(DEF_N, DEF_BT);
    localparam int PERIODIC_BIT = cmd_periodic_bit(DEF_N, DEF_BT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tgen_state_t;

endpackage

// File: rtl/mod_tgen_dly.sv
// Fixed-depth register delay line with asynchronous active-low clear of every stage.
module mod_tgen_dly #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/mod_tgen.sv
// Time-base generator: accepts waveform commands, drives the parameter-memory address
// and emits t / t_valid / sync delayed to line up with the memory read data.
module mod_tgen
    import mod_pkg::*;
#(
    parameter int BT      = 8,
    parameter int N       = 10,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N+BT+1:0] s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [N-1:0]    mem_addr,
    output logic [BT-1:0]   t_out,
    output logic            t_valid,
    output logic            sync,
    output logic            busy
);

    localparam int L_LEN_LSB  = cmd_len_lsb(N);
    localparam int L_PHRST    = cmd_phrst_bit(N, BT);
    localparam int L_PERIODIC = cmd_periodic_bit(N, BT);

    tgen_state_t state, state_next;

    logic [BT-1:0] t_int;
    logic [BT-1:0] len_r;
    logic          phrst_r;
    logic          periodic_r;
    logic          first_r;
    logic          last;
    logic          ready;
    logic          load;
    logic          wrap;
    logic          sync_int;
    logic          t_int_valid;
    logic [BT+1:0] dly_q;

    assign last = (t_int == len_r);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        load       = 1'b0;
        wrap       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (s_axis_tvalid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    ready = 1'b1;
                    if (s_axis_tvalid)   load = 1'b1;
                    else if (periodic_r) wrap = 1'b1;
                    else                 state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // first_r marks t_int=0 of a freshly accepted command; a periodic wrap clears it so no sync repeats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_addr   <= '0;
            t_int      <= '0;
            len_r      <= '0;
            phrst_r    <= 1'b0;
            periodic_r <= 1'b0;
            first_r    <= 1'b0;
        end else if (load) begin
            mem_addr   <= s_axis_tdata[N-1:0];
            len_r      <= s_axis_tdata[L_LEN_LSB +: BT];
            phrst_r    <= s_axis_tdata[L_PHRST];
            periodic_r <= s_axis_tdata[L_PERIODIC];
            t_int      <= '0;
            first_r    <= 1'b1;
        end else if (state == RUN) begin
            first_r <= 1'b0;
            if (wrap)       t_int <= '0;
            else if (!last) t_int <= t_int + 1'b1;
        end
    end

    assign s_axis_tready = ready & rstn;
    assign busy          = (state == RUN);
    assign t_int_valid   = (state == RUN);
    assign sync_int      = (state == RUN) & first_r & phrst_r;

    mod_tgen_dly #(
        .DEPTH (MEM_LAT),
        .WIDTH (BT + 2)
    ) u_dly (
        .clk  (clk),
        .rstn (rstn),
        .d    ({sync_int, t_int_valid, t_int}),
        .q    (dly_q)
    );

    assign {sync, t_valid, t_out} = dly_q;

endmodule

// File: tb/tb_mod_tgen.sv
// Randomised and directed bench for mod_tgen, checked against a sample-queue model of the command stream.
module tb_mod_tgen;

    localparam int BT  = 8;
    localparam int N   = 10;
    localparam int LAT = 2;

    typedef struct packed {
        logic           v;
        logic           s;
        logic [BT-1:0]  t;
    } samp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N+BT+1:0] s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [N-1:0]    mem_addr;
    logic [BT-1:0]   t_out;
    logic            t_valid;
    logic            sync;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Model: q holds the remaining samples of the running command, front = sample presented now.
    samp_t           q[$];
    samp_t           hist[8];
    samp_t           e;
    logic [N+BT+1:0] cmds[$];
    logic [N-1:0]    exp_addr = '0;
    logic [BT-1:0]   m_len = '0;
    logic            m_per = 1'b0;
    logic            last_hs = 1'b0;
    int              cyc = 0;

    mod_tgen #(.BT(BT), .N(N), .MEM_LAT(LAT)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .mem_addr      (mem_addr),
        .t_out         (t_out),
        .t_valid       (t_valid),
        .sync          (sync),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [N+BT+1:0] mk(input logic [N-1:0] a, input logic [BT-1:0] l,
                                           input logic ph, input logic pe);
        return {pe, ph, l, a};
    endfunction

    task automatic model_clear();
        q.delete();
        cmds.delete();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        exp_addr      = '0;
        m_len         = '0;
        m_per         = 1'b0;
        last_hs       = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic step();
        logic rdy;
        logic popped;
        logic hs;
        rdy = (q.size() <= 1);
        @(posedge clk);
        hs     = s_axis_tvalid && rdy;
        popped = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            popped = 1'b1;
        end
        if (hs) begin
            exp_addr = s_axis_tdata[N-1:0];
            m_len    = s_axis_tdata[N +: BT];
            m_per    = s_axis_tdata[N+BT+1];
            for (int i = 0; i <= int'(m_len); i++)
                q.push_back(samp_t'{v: 1'b1, s: (i == 0) && s_axis_tdata[N+BT], t: BT'(i)});
        end else if (popped && q.size() == 0 && m_per) begin
            for (int i = 0; i <= int'(m_len); i++)
                q.push_back(samp_t'{v: 1'b1, s: 1'b0, t: BT'(i)});
        end
        cyc++;
        hist[cyc & 7] = (q.size() > 0) ? q[0] : samp_t'('0);
        last_hs = hs;
        @(negedge clk);
    endtask

    task automatic cycle();
        if (last_hs) s_axis_tvalid = 1'b0;
        last_hs = 1'b0;
        if (!s_axis_tvalid && cmds.size() > 0) begin
            s_axis_tdata  = cmds.pop_front();
            s_axis_tvalid = 1'b1;
        end
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset tready got=%b want=0", s_axis_tready); end
        total++; if (t_valid !== 1'b0) begin bad++; $display("FAIL reset t_valid got=%b want=0", t_valid); end
        total++; if (t_out !== '0) begin bad++; $display("FAIL reset t_out got=%0d want=0", t_out); end
        total++; if (sync !== 1'b0) begin bad++; $display("FAIL reset sync got=%b want=0", sync); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset mem_addr got=%0d want=0", mem_addr); end
        rstn = 1'b1;
        repeat (3) begin
            step();
            total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL reset_release tready got=%b want=1", s_axis_tready); end
            total++; if (t_valid !== 1'b0) begin bad++; $display("FAIL reset_release t_valid got=%b want=0", t_valid); end
        end
    endtask

    task automatic test_one_shot();
        do_reset();
        cmds.push_back(mk(10'd5, 8'd3, 1'b1, 1'b0));
        repeat (10) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL one_shot t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL one_shot sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL one_shot t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL one_shot busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL one_shot tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL one_shot mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmds.push_back(mk(10'd2, 8'd2, 1'b1, 1'b0));
        cmds.push_back(mk(10'd9, 8'd1, 1'b0, 1'b0));
        repeat (10) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL b2b t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL b2b sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL b2b t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL b2b busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL b2b tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL b2b mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
    endtask

    task automatic test_periodic();
        do_reset();
        cmds.push_back(mk(10'd7, 8'd1, 1'b1, 1'b1));
        repeat (8) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL periodic t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL periodic sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL periodic t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL periodic busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL periodic tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL periodic mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
        cmds.push_back(mk(10'd20, 8'd2, 1'b0, 1'b0));
        repeat (12) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL periodic_switch t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL periodic_switch sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL periodic_switch t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL periodic_switch busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL periodic_switch tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL periodic_switch mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        for (int i = 0; i < 6; i++) cmds.push_back(mk(N'(i * 3 + 1), 8'd0, 1'(i), 1'b0));
        repeat (10) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL len_zero t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL len_zero sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL len_zero t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL len_zero busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL len_zero tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL len_zero mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
    endtask

    task automatic test_random();
        logic [BT-1:0] len;
        do_reset();
        repeat (900) begin
            if (cmds.size() < 2 && $urandom_range(0, 3) == 0) begin
                len = ($urandom_range(0, 11) == 0) ? 8'd255 : BT'($urandom_range(0, 5));
                cmds.push_back(mk(N'($urandom), len, 1'($urandom), $urandom_range(0, 4) == 0));
            end
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL random t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL random sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            if (e.v) begin total++; if (t_out !== e.t) begin bad++; $display("FAIL random t_out cyc=%0d got=%0d want=%0d", cyc, t_out, e.t); end end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL random busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL random tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
            total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL random mem_addr cyc=%0d got=%0d want=%0d", cyc, mem_addr, exp_addr); end
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        cmds.push_back(mk(10'd33, 8'd5, 1'b1, 1'b0));
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (t_valid === 1'b1 && t_out === 8'd2) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL reset_mid wait_t2 got=timeout want=t_out==2"); end
        rstn = 1'b0;
        #1;
        total++; if (t_valid !== 1'b0) begin bad++; $display("FAIL reset_mid t_valid got=%b want=0", t_valid); end
        total++; if (t_out !== '0) begin bad++; $display("FAIL reset_mid t_out got=%0d want=0", t_out); end
        total++; if (sync !== 1'b0) begin bad++; $display("FAIL reset_mid sync got=%b want=0", sync); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy got=%b want=0", busy); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mid mem_addr got=%0d want=0", mem_addr); end
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_mid tready got=%b want=0", s_axis_tready); end
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) begin
            cycle();
            e = hist[(cyc - LAT) & 7];
            total++; if (t_valid !== e.v) begin bad++; $display("FAIL reset_mid_after t_valid cyc=%0d got=%b want=%b", cyc, t_valid, e.v); end
            total++; if (sync !== (e.v & e.s)) begin bad++; $display("FAIL reset_mid_after sync cyc=%0d got=%b want=%b", cyc, sync, e.v & e.s); end
            total++; if (busy !== (q.size() != 0)) begin bad++; $display("FAIL reset_mid_after busy cyc=%0d got=%b want=%b", cyc, busy, q.size() != 0); end
            total++; if (s_axis_tready !== (q.size() <= 1)) begin bad++; $display("FAIL reset_mid_after tready cyc=%0d got=%b want=%b", cyc, s_axis_tready, q.size() <= 1); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_clear();
        test_reset();
        test_one_shot();
        test_back_to_back();
        test_periodic();
        test_len_zero();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_tgen.md
# mod_tgen

Time-base and parameter-sequencing stage that sits directly upstream of the DDS modulation stage. It accepts waveform commands on an AXI-Stream slave and drives the parameter-memory read address. It generates the per-sample time index `t` with its valid and the phase `sync` pulse. All of these are pipelined so that `t`, `t_valid` and `sync` arrive at the modulator in the same cycle as the parameter word they belong to. It supports one-shot and periodic (self-repeating) envelopes and chains back-to-back commands without gaps.

## Interface
- `BT`, 8: bits of `t`; envelope length is 1..2^BT samples.
- `N`, 10: parameter-memory address bits.
- `MEM_LAT`, 2: read latency of the parameter memory, in cycles from `mem_addr` to data (≥1).

- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  N+BT+2  command, with fields:
  - `[N-1:0]` ADDR
  - `[N+BT-1:N]` LEN (number of samples − 1)
  - `[N+BT]` PHRST
  - `[N+BT+1]` PERIODIC
- `s_axis_tvalid`  in  1  command valid.
- `s_axis_tready`  out  1  command accepted when high together with tvalid.
- `mem_addr`  out  N  parameter-memory read address.
- `t_out`  out  BT  time index, aligned with memory data.
- `t_valid`  out  1  `t_out` valid.
- `sync`  out  1  phase-reset pulse, aligned with `t_out`.
- `busy`  out  1  a command is executing (undelayed).

## Operation
- The FSM has two states, IDLE and RUN. Reset state is IDLE.
- **IDLE**
  - `s_axis_tready`=1.
  - On handshake: latch LEN, PHRST and PERIODIC; `mem_addr`←ADDR; `t_int`←0; go to RUN.
- **RUN**
  - One sample per cycle; `t_int_valid`=1.
  - `t_int` increments while `t_int`<LEN.
  - `s_axis_tready`=1 only on the last sample (`t_int`==LEN); 0 otherwise.
- **Last sample**, evaluated in priority order:
  1. If tvalid is high: accept the new command seamlessly. The next cycle is `t_int`=0 of the new command, with no bubble.
  2. Else if PERIODIC: wrap `t_int` to 0 with the same `mem_addr`. No sync is generated on the wrap.
  3. Else: go to IDLE; `t_int_valid`=0.
- A periodic command runs until a new command arrives. There is no other stop mechanism.
- `sync_int`=1 only on `t_int`=0 of a command whose PHRST=1.
- `t_out`, `t_valid` and `sync` are `t_int`, `t_int_valid` and `sync_int` delayed by MEM_LAT registers.
- `busy` = (state==RUN).
- LEN=0 gives a 1-sample command: `s_axis_tready` is high in its only RUN cycle.
- `mem_addr` holds its value in IDLE. It changes only on a handshake.

## Timing
- Handshake at edge E0 → at E0: `mem_addr`=ADDR, `t_int`=0, `busy`=1.
- `t_valid`=1, `t_out`=0 and `sync` (if PHRST) appear after edge E0+MEM_LAT.
- An accepted command produces exactly LEN+1 consecutive `t_valid` cycles (one-shot).
- Back-to-back commands give a continuous `t_valid`; `t_out` runs …,LEN,0,…
- Throughput: 1 sample/cycle; no stalls. The downstream stage has no backpressure.
- Reset values: `s_axis_tready`=0 while `rstn`=0, then 1 after release. `mem_addr`=0, `t_out`=0, `t_valid`=0, `sync`=0, `busy`=0.
- Reset mid-command: all state and delay lines clear immediately and asynchronously. No residual `t_valid` appears after release.
- `t_int` never exceeds LEN. Wrap is only from LEN to 0. With LEN=2^BT−1, counting wraps naturally at BT bits.

## Structure
- Package `mod_pkg` holds:
  - Localparams for the command field offsets (ADDR_LSB, LEN_LSB, PHRST_BIT, PERIODIC_BIT) as functions of N and BT.
  - The state enum `tgen_state_t` {IDLE, RUN}.
- Sub-module `mod_tgen_dly`: parameterised (depth, width) delay line with asynchronous active-low reset. Instantiate it once for {`sync_int`, `t_int_valid`, `t_int`} at depth MEM_LAT.
- The FSM, counter and address register live in `mod_tgen`.

## Test plan
- One-shot ADDR=5, LEN=3, PHRST=1, MEM_LAT=2 → after handshake at E0: `mem_addr`=5 at E0; `t_out`=0,1,2,3 valid from E0+2; `sync` high only with `t_out`=0; `t_valid` low after 4 cycles; `busy` low 4 cycles after E0.
- Back-to-back: cmd A (LEN=2), cmd B (ADDR=9, LEN=1, PHRST=0) held valid → B accepted on A's last sample; `t_out`=0,1,2,0,1 continuous; `mem_addr`=9 one cycle after A's t=2; no `sync` for B.
- Periodic LEN=1, PHRST=1, no new command → `t_out` 0,1,0,1,… indefinitely; `sync` only on the first 0; `s_axis_tready` toggles high on every t=1.
- Periodic then new command on the 3rd wrap → switch happens exactly at wrap; no missing or duplicated sample.
- LEN=0 commands streamed continuously → `t_out`=0 every cycle; `mem_addr` updates every cycle; `s_axis_tready` stays high.
- Assert `rstn`=0 mid-command at `t_out`=2 → all outputs 0 immediately; after release: IDLE, `s_axis_tready`=1, no stray `t_valid`.
